// File: rtl/ifu_pkg.sv
// Shared types and AXI encodings for the instruction prefetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    R     = 2'd2,
    DRAIN = 2'd3
  } ifu_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_prefetch_if.sv
// AXI4 read channels plus the IDU-facing instruction handshake.
interface ifu_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [3:0]        rid;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic              out_err;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
           out_valid, out_pc, out_inst, out_err,
    input  arready, rvalid, rdata, rresp, rlast, rid, out_ready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
           out_valid, out_pc, out_inst, out_err,
    output arready, rvalid, rdata, rresp, rlast, rid, out_ready
  );
endinterface

// File: rtl/ifu_fifo.sv
// Prefetch FIFO: circular buffer with synchronous flush and occupancy count.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/ifu_prefetch.sv
// Burst-fetching AXI4 instruction prefetcher with redirect flush.
// Define IFU_PERF_CNT_EN to add saturating perf_fetched/perf_flushed/perf_stall outputs.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter int                BURST_LEN  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h8000_0000),
  parameter logic [3:0]        AXI_ID     = 4'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  ifu_prefetch_if.master    bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed,
  output logic [31:0]       perf_stall
`endif
);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + DATA_W + 1;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [ADDR_W-1:0] beat_pc_q, beat_pc_d;
  logic              halted_q, halted_d;
  logic              redir_pend_q, redir_pend_d;

  logic [CNT_W-1:0]   fifo_cnt;
  logic [ENTRY_W-1:0] head;
  logic               head_err;
  logic               push, pop, beat;
  logic [CNT_W:0]     free;
  logic [7:0]         beats;

  // Beats left before the next BURST_LEN-word boundary.
  function automatic logic [7:0] beats_f(input logic [ADDR_W-1:0] pc);
    logic [7:0] off;
    off = 8'((pc >> 2) & ADDR_W'(BURST_LEN - 1));
    return 8'(BURST_LEN) - off;
  endfunction

  assign beats = beats_f(fetch_pc_q);
  assign beat  = bus.rvalid && bus.rready;
  assign pop   = bus.out_valid && bus.out_ready && !redirect_valid;
  assign free  = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, fifo_cnt} + (CNT_W+1)'(pop);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    beat_pc_d    = beat_pc_q;
    halted_d     = halted_q;
    redir_pend_d = redir_pend_q;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect_valid && !halted_q && (32'(free) >= 32'(beats))) begin
          state_d      = AR;
          araddr_d     = fetch_pc_q;
          arlen_d      = beats - 8'd1;
          fetch_pc_d   = fetch_pc_q + (ADDR_W'(beats) << 2);
          redir_pend_d = 1'b0;
        end
      end
      AR: begin
        // The address stays posted until accepted; a redirect only turns the burst into a drain.
        if (bus.arready) begin
          beat_pc_d = araddr_q;
          state_d   = (redirect_valid || redir_pend_q) ? DRAIN : R;
        end else if (redirect_valid) begin
          redir_pend_d = 1'b1;
        end
      end
      R: begin
        if (beat) begin
          if (redirect_valid) begin
            state_d = bus.rlast ? IDLE : DRAIN;
          end else begin
            push      = 1'b1;
            beat_pc_d = beat_pc_q + ADDR_W'(4);
            if (bus.rresp != RESP_OKAY) begin
              halted_d = 1'b1;
              state_d  = bus.rlast ? IDLE : DRAIN;
            end else if (bus.rlast) begin
              state_d = IDLE;
            end
          end
        end else if (redirect_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beat && bus.rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      halted_q     <= 1'b0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      halted_q     <= halted_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    araddr_q  <= araddr_d;
    arlen_q   <= arlen_d;
    beat_pc_q <= beat_pc_d;
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({beat_pc_q, bus.rdata, (bus.rresp != RESP_OKAY)}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_cnt)
  );

  assign bus.arvalid   = (state_q == AR);
  assign bus.araddr    = araddr_q;
  assign bus.arlen     = arlen_q;
  assign bus.arid      = AXI_ID;
  assign bus.arsize    = SIZE_4B;
  assign bus.arburst   = BURST_INCR;
  assign bus.rready    = (state_q == R) || (state_q == DRAIN);
  assign bus.out_valid = (fifo_cnt != '0);
  assign {bus.out_pc, bus.out_inst, head_err} = head;
  assign bus.out_err   = bus.out_valid && head_err;

  logic unused_rid;
  assign unused_rid = ^bus.rid;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetched_q, flushed_q, stall_q;
  logic [31:0] flush_amt;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // Flushed work = entries dropped by a redirect plus beats accepted but not kept.
  assign flush_amt = (redirect_valid ? 32'(fifo_cnt) : 32'd0) + ((beat && !push) ? 32'd1 : 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= sat_add(fetched_q, 32'(push));
      flushed_q <= sat_add(flushed_q, flush_amt);
      stall_q   <= sat_add(stall_q, 32'(bus.out_ready && !bus.out_valid));
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
  assign perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: bench-driven AXI slave and IDU with hand-computed expectations.
module tb_ifu_prefetch;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  int          n_checks = 0;
  int          n_fail   = 0;
  ifu_entry_t  got_q[$];

  ifu_prefetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

  ifu_prefetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Record every accepted instruction just before the edge that pops it.
  always @(negedge clk) begin
    #4;
    if (rst_n && bus.out_valid && bus.out_ready && !redirect_valid)
      got_q.push_back('{pc: bus.out_pc, inst: bus.out_inst, err: bus.out_err});
  end

  task automatic check_out(input string tag, input int idx, input logic [31:0] pc, input logic err);
    if (idx < got_q.size()) begin
      check({tag, "_pc"},   got_q[idx].pc,          pc);
      check({tag, "_inst"}, got_q[idx].inst,        inst_of(pc));
      check({tag, "_err"},  32'(got_q[idx].err),    32'(err));
    end else begin
      check({tag, "_present"}, 32'(got_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic ar_accept(input string tag, input bit redir, input logic [31:0] rpc,
                           input logic [31:0] exp_addr, input logic [7:0] exp_len);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (bus.arvalid) ok = 1;
      else @(negedge clk);
    end
    check({tag, "_seen"}, 32'(ok), 32'd1);
    check({tag, "_addr"}, bus.araddr, exp_addr);
    check({tag, "_len"},  32'(bus.arlen), 32'(exp_len));
    check({tag, "_burst"}, 32'(bus.arburst), 32'(BURST_INCR));
    check({tag, "_size"}, 32'(bus.arsize), 32'(SIZE_4B));
    check({tag, "_id"},   32'(bus.arid), 32'd0);
    bus.arready = 1'b1;
    if (redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rpc;
    end
    @(negedge clk);
    bus.arready    = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [31:0] base, input int n, input int err_idx,
                            input int redir_idx, input logic [31:0] rpc);
    for (int k = 0; k < n; k++) begin
      int g;
      g = 0;
      bus.rvalid = 1'b1;
      bus.rdata  = inst_of(base + 32'(4 * k));
      bus.rresp  = (k == err_idx) ? 2'b10 : 2'b00;
      bus.rlast  = (k == n - 1);
      if (k == redir_idx) begin
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
      end
      while (!bus.rready && g < 50) begin
        @(negedge clk);
        g++;
      end
      check("rready", 32'(bus.rready), 32'd1);
      @(negedge clk);
      redirect_valid = 1'b0;
      if (k == redir_idx) check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
  endtask

  task automatic watch_no_ar(input string tag, input int n);
    bit seen = 0;
    repeat (n) begin
      @(negedge clk);
      seen |= bus.arvalid;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b0;
    bus.rdata      = '0;
    bus.rresp      = 2'b00;
    bus.rlast      = 1'b0;
    bus.rid        = 4'd0;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arvalid",   32'(bus.arvalid),   32'd0);
    check("rst_rready",    32'(bus.rready),    32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);
    rst_n = 1'b1;

    // Streaming with a zero-latency consumer
    bus.out_ready = 1'b1;
    ar_accept("ar0", 0, 0, 32'h8000_0000, 8'd3);
    send_burst(32'h8000_0000, 4, -1, -1, 0);
    ar_accept("ar1", 0, 0, 32'h8000_0010, 8'd3);
    check("t1_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_out("t1", i, 32'h8000_0000 + 32'(4 * i), 1'b0);

    // Stalled consumer: one burst fills the FIFO, credit blocks the next
    got_q.delete();
    bus.out_ready = 1'b0;
    send_burst(32'h8000_0010, 4, -1, -1, 0);
    watch_no_ar("full_no_ar", 12);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_head_pc",   bus.out_pc, 32'h8000_0010);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    watch_no_ar("one_pop_no_ar", 8);
    bus.out_ready = 1'b1;
    ar_accept("ar2", 0, 0, 32'h8000_0020, 8'd3);
    for (int i = 0; i < 4; i++) check_out("t3", i, 32'h8000_0010 + 32'(4 * i), 1'b0);

    // Redirect on beat 2 of 4
    got_q.delete();
    bus.out_ready = 1'b0;
    send_burst(32'h8000_0020, 4, -1, 2, 32'h8000_0108);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    ar_accept("ar_redir", 0, 0, 32'h8000_0108, 8'd1);
    check("no_old_pc", 32'(got_q.size()), 32'd0);
    send_burst(32'h8000_0108, 2, -1, -1, 0);
    ar_accept("ar_aligned", 0, 0, 32'h8000_0110, 8'd3);
    check_out("t4a", 0, 32'h8000_0108, 1'b0);
    check_out("t4b", 1, 32'h8000_010C, 1'b0);

    // Error response on beat 1 halts fetching
    got_q.delete();
    bus.out_ready = 1'b0;
    send_burst(32'h8000_0110, 4, 1, -1, 0);
    bus.out_ready = 1'b1;
    watch_no_ar("halt_no_ar", 15);
    check("err_count", 32'(got_q.size()), 32'd2);
    check_out("err0", 0, 32'h8000_0110, 1'b0);
    check_out("err1", 1, 32'h8000_0114, 1'b1);

    // Redirect while idle, then redirect on the AR handshake itself
    got_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0108;
    @(negedge clk);
    redirect_valid = 1'b0;
    ar_accept("ar_idle_redir", 1, 32'h8000_0000, 32'h8000_0108, 8'd1);
    send_burst(32'h8000_0108, 2, -1, -1, 0);
    ar_accept("ar_resume", 0, 0, 32'h8000_0000, 8'd3);
    check("hs_drain_empty", 32'(got_q.size()), 32'd0);
    send_burst(32'h8000_0000, 4, -1, -1, 0);
    ar_accept("ar_after_resume", 0, 0, 32'h8000_0010, 8'd3);
    for (int i = 0; i < 4; i++) check_out("t6", i, 32'h8000_0000 + 32'(4 * i), 1'b0);

    // Reset in the middle of a burst
    bus.rvalid = 1'b1;
    bus.rdata  = inst_of(32'h8000_0010);
    bus.rlast  = 1'b0;
    repeat (2) @(negedge clk);
    bus.rvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_arvalid",   32'(bus.arvalid),   32'd0);
    check("mid_rst_rready",    32'(bus.rready),    32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    ar_accept("ar_post_rst", 0, 0, 32'h8000_0000, 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Next-generation instruction fetch unit: AXI4 read master that issues INCR bursts and buffers fetched instructions in a parametrised prefetch FIFO.
- Presents {pc, inst, err} to the IDU over a valid/ready handshake.
- Accepts a redirect (branch/jump/trap target) that flushes buffered and in-flight fetches.
- Sits between the PC generator/EXU redirect path and the IDU, and replaces the single-beat, one-outstanding fetcher.

Parameters:
- ADDR_W, 32, address and PC width.
- DATA_W, 32, instruction width (one instruction per beat); must equal 32.
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥ BURST_LEN.
- BURST_LEN, 4, maximum beats per burst; power of two, 1..16.
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- AXI_ID, 4'd0, constant value driven on arid.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address; word-aligned
- out_valid  out  1  FIFO head valid
- out_ready  in  1  IDU accepts head
- out_pc  out  ADDR_W  PC of head instruction
- out_inst  out  DATA_W  head instruction
- out_err  out  1  head fetched with rresp != OKAY
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- araddr  out  ADDR_W  burst start address
- arid  out  4  = AXI_ID
- arlen  out  8  beats-1
- arsize  out  3  = 3'b010
- arburst  out  2  = 2'b01 (INCR)
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rid  in  4  ignored; single ID, in-order

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; fetch_pc=RESET_PC; FIFO empty.
  - arvalid=0, rready=0, out_valid=0, out_err=0, halted=0.
- FSM states:
  - IDLE → AR when !halted and free slots ≥ beats of the next burst.
  - AR: arvalid=1, araddr/arlen held stable until arready. On handshake → R.
  - R: rready=1. Each beat pushes {beat_pc, rdata, rresp!=0} into the FIFO. On rlast → IDLE.
  - DRAIN: rready=1; beats are discarded, nothing is pushed. On rlast → IDLE.
- Burst length: beats = BURST_LEN − (fetch_pc[2+:log2(BURST_LEN)]), so no burst crosses a BURST_LEN*4-byte boundary. arlen=beats−1. After issue, fetch_pc += beats*4 (mod 2^ADDR_W).
- Credit rule: a burst issues only when the FIFO can absorb all of its beats, counting entries popped in the same cycle. rready is never deasserted mid-burst.
- FIFO output: out_* driven from the head entry; pop on out_valid & out_ready. Push and pop in the same cycle are both allowed when full. Latency from the rvalid beat to out_valid is 1 cycle.
- Redirect (takes priority over every other event that cycle):
  - FIFO cleared; fetch_pc=redirect_pc; halted=0.
  - IDLE → IDLE.
  - AR: arvalid stays high with the old address until the handshake (AXI stability), then → DRAIN.
  - R: → DRAIN, unless rlast arrives that cycle, in which case → IDLE.
  - DRAIN: stays in DRAIN.
  - A pop in the same cycle is ignored.
  - out_valid=0 the next cycle.
- Error: a beat with rresp!=0 is pushed with err=1. The remaining beats of that burst are discarded. halted=1, and no new AR issues until a redirect.
- Reset mid-burst returns all state to reset values. The interconnect is reset in the same domain.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined: adds output ports perf_fetched[31:0], perf_flushed[31:0], perf_stall[31:0], all reset to 0, saturating.
  - perf_fetched counts pushed beats.
  - perf_flushed counts FIFO entries cleared plus beats discarded in DRAIN.
  - perf_stall counts cycles with out_ready=1 && out_valid=0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ifu_pkg:
  - FSM state enum {IDLE, AR, R, DRAIN}.
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00.
  - FIFO entry struct {pc, inst, err}.
- One sub-module, ifu_fifo (parametrised DEPTH/entry width): sync flush, count output, push/pop.

Test Plan:
- Reset release, 0-latency memory, out_ready=1 → AR araddr=0x8000_0000, arlen=3, arburst=01. out_pc sequence 0x8000_0000, 04, 08, 0C; then AR at 0x8000_0010.
- Redirect to 0x8000_0108 while idle → AR araddr=0x8000_0108, arlen=1 (boundary-aligned). Next burst at 0x8000_0110, arlen=3.
- out_ready=0 with FIFO_DEPTH=4 → exactly one burst of 4 fills the FIFO. No AR until a pop frees 4 slots; arvalid stays 0 while count>0.
- Redirect during beat 2 of 4 → remaining beats are consumed with no push; no output with old PCs appears. The next AR uses the redirect address after rlast.
- rresp=2'b10 on beat 1 → that entry is output with out_err=1, later beats are discarded, and no further AR. A redirect to 0x8000_0000 resumes fetching.
- Redirect asserted in the same cycle as the AR handshake → FSM enters DRAIN and discards the whole burst. Then AR at redirect_pc.
